// File: rtl/alu_result_serializer_pkg.sv
// alu_ser_pkg: shared types and constants for the ALU result serializer.
//   - tag constants for the 4-bit op tag carried in each frame
//   - FRAME_LEN: serial frame length in bits
//   - entry_t: one FIFO entry (tag + result)
//   - op_to_tag: priority encoder from one-hot op select to tag
package alu_ser_pkg;

  localparam int FRAME_LEN = 14;

  localparam logic [3:0] TAG_NONE = 4'd0;
  localparam logic [3:0] TAG_ADD  = 4'd1;
  localparam logic [3:0] TAG_NEGA = 4'd2;
  localparam logic [3:0] TAG_NEGB = 4'd3;
  localparam logic [3:0] TAG_SUB  = 4'd4;
  localparam logic [3:0] TAG_MUL  = 4'd5;
  localparam logic [3:0] TAG_AND  = 4'd6;
  localparam logic [3:0] TAG_OR   = 4'd7;
  localparam logic [3:0] TAG_XOR  = 4'd8;

  typedef struct packed {
    logic [3:0] tag;
    logic [7:0] res;
  } entry_t;

  typedef enum logic {IDLE, SHIFT} state_t;

  // Same priority as the ALU: bit7 wins.
  function automatic logic [3:0] op_to_tag(input logic [7:0] op);
    if (op[7])      return TAG_ADD;
    else if (op[6]) return TAG_NEGA;
    else if (op[5]) return TAG_NEGB;
    else if (op[4]) return TAG_SUB;
    else if (op[3]) return TAG_MUL;
    else if (op[2]) return TAG_AND;
    else if (op[1]) return TAG_OR;
    else if (op[0]) return TAG_XOR;
    else            return TAG_NONE;
  endfunction

endpackage

// File: rtl/alu_result_serializer_if.sv
// alu_result_serializer_if: capture bus in, serial frame and FIFO status out.
//   master: drives cap/res_in/op_in, observes ser_out/frame_active/status
//   slave : the serializer
interface alu_result_serializer_if #(parameter int DEPTH = 4);
  logic                     cap;
  logic [7:0]               res_in;
  logic [7:0]               op_in;
  logic                     ser_out;
  logic                     frame_active;
  logic [$clog2(DEPTH):0]   fifo_count;
  logic                     full;
  logic                     empty;
  logic                     overflow;

  modport master (output cap, res_in, op_in,
                  input  ser_out, frame_active, fifo_count, full, empty, overflow);
  modport slave  (input  cap, res_in, op_in,
                  output ser_out, frame_active, fifo_count, full, empty, overflow);
endinterface

// File: rtl/result_fifo.sv
// result_fifo: synchronous FIFO, W bits wide, DEPTH (power of two) deep.
//   push/wdata : write when push && !full
//   pop/rdata  : rdata is the head (combinational); advance when pop && !empty
//   full/empty/count : registered, updated on the same edge as push/pop
module result_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          do_push, do_pop;
  logic [AW:0]   count_nxt;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rptr];

  always_comb begin
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  // Pointers are exactly AW bits, so they wrap modulo DEPTH for free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == (AW+1)'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end
endmodule

// File: rtl/alu_result_serializer.sv
// alu_result_serializer: captures {tag, result} pairs into a FIFO and drains
// them as 14-bit frames on ser_out: start 0, tag[3:0], res[7:0] (MSB first),
// stop 1. Frames are sent back-to-back while entries remain.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of alu_result_serializer_if
module alu_result_serializer
  import alu_ser_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  alu_result_serializer_if.slave  bus
);
  entry_t                 wentry, rentry;
  logic                   full, empty, push, pop;
  logic [$clog2(DEPTH):0] count;

  state_t                 state;
  logic [FRAME_LEN-1:0]   sr;
  logic [3:0]             bcnt;
  logic                   fa, ovf;

  assign wentry = '{tag: op_to_tag(bus.op_in), res: bus.res_in};
  // A capture while full is dropped even if a pop frees a slot on this edge.
  assign push   = bus.cap & ~full;
  // Pop when idle, or on the stop-bit cycle so the next frame follows with no gap.
  assign pop    = ~empty & ((state == IDLE) | (bcnt == '0));

  result_fifo #(.DEPTH(DEPTH), .W(12)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (wentry),
    .pop   (pop),
    .rdata (rentry),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // sr back-fills with 1s, so ser_out = sr[MSB] naturally idles high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sr    <= '1;
      bcnt  <= '0;
      fa    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      if (bus.cap & full) ovf <= 1'b1;
      if (pop) begin
        state <= SHIFT;
        sr    <= {1'b0, rentry.tag, rentry.res, 1'b1};
        bcnt  <= 4'(FRAME_LEN - 1);
        fa    <= 1'b1;
      end else if (state == SHIFT) begin
        if (bcnt == '0) begin
          state <= IDLE;
          sr    <= '1;
          fa    <= 1'b0;
        end else begin
          sr    <= {sr[FRAME_LEN-2:0], 1'b1};
          bcnt  <= bcnt - 1'b1;
        end
      end
    end
  end

  assign bus.ser_out      = sr[FRAME_LEN-1];
  assign bus.frame_active = fa;
  assign bus.fifo_count   = count;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.overflow     = ovf;
endmodule

// File: tb/tb_alu_result_serializer.sv
module tb_alu_result_serializer;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_result_serializer_if #(.DEPTH(DEPTH)) bus();
  alu_result_serializer #(.DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;

  // bench-side occupancy model and scoreboard
  logic [11:0] mq[$];
  logic [13:0] exp_q[$];
  bit          m_busy;
  int          m_left;
  bit          m_ovf;
  logic [13:0] rx, last_frame;
  int          rx_n, run, last_run, frames;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] tag_of(input logic [7:0] op);
    for (int i = 7; i >= 0; i--)
      if (op[i]) return 4'(8 - i);
    return 4'd0;
  endfunction

  task automatic model_clear();
    mq.delete(); exp_q.delete();
    m_busy = 0; m_left = 0; m_ovf = 0;
    rx_n = 0; run = 0;
  endtask

  // Called at a negedge: drive inputs, take one rising edge, update the model,
  // then check at the following negedge.
  task automatic cyc(input bit c, input logic [7:0] r, input logic [7:0] o);
    bit push, pop;
    bus.cap = c; bus.res_in = r; bus.op_in = o;
    @(posedge clk);
    push = c && (mq.size() < DEPTH);
    if (c && !push) m_ovf = 1;
    pop = (mq.size() > 0) && (!m_busy || m_left == 0);
    if (pop) begin
      void'(mq.pop_front()); m_busy = 1; m_left = 13;
    end else if (m_busy) begin
      if (m_left == 0) m_busy = 0; else m_left--;
    end
    if (push) begin
      mq.push_back({tag_of(o), r});
      exp_q.push_back({1'b0, tag_of(o), r, 1'b1});
    end
    @(negedge clk);
    chk("count", 32'(bus.fifo_count), mq.size());
    chk("full", 32'(bus.full), 32'(mq.size() == DEPTH));
    chk("empty", 32'(bus.empty), 32'(mq.size() == 0));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    chk("frame_active", 32'(bus.frame_active), 32'(m_busy));
    if (!m_busy) chk("idle_ser", 32'(bus.ser_out), 32'd1);
    if (bus.frame_active) begin
      rx = {rx[12:0], bus.ser_out}; rx_n++; run++;
      if (rx_n == 14) begin
        if (exp_q.size() == 0) chk("frame_unexpected", 32'(rx), 32'hFFFFFFFF);
        else chk("frame", 32'(rx), 32'(exp_q.pop_front()));
        last_frame = rx; rx_n = 0; frames++;
      end
    end else begin
      if (run != 0) last_run = run;
      run = 0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (!(mq.size() == 0 && exp_q.size() == 0 && !m_busy && run == 0) && n < 300) begin
      cyc(0, 8'h00, 8'h00); n++;
    end
    if (n >= 300) chk("drain_timeout", 32'(n), 32'd0);
  endtask

  initial begin
    int f0;
    bus.cap = 0; bus.res_in = 0; bus.op_in = 0;
    rx = 0; last_frame = 0; last_run = 0; frames = 0;
    model_clear();
    rst_n = 0;
    @(negedge clk); @(negedge clk);
    chk("rst_ser", 32'(bus.ser_out), 32'd1);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_count", 32'(bus.fifo_count), 32'd0);
    chk("rst_ovf", 32'(bus.overflow), 32'd0);
    chk("rst_fa", 32'(bus.frame_active), 32'd0);
    rst_n = 1;
    cyc(0, 8'h00, 8'h00);

    // single capture: mul, A5
    f0 = frames;
    cyc(1, 8'hA5, 8'b0000_1000);
    chk("lat_count", 32'(bus.fifo_count), 32'd1);
    cyc(0, 8'h00, 8'h00);
    chk("lat_start", 32'(bus.ser_out), 32'd0);
    chk("lat_fa", 32'(bus.frame_active), 32'd1);
    drain();
    chk("single_frame", 32'(last_frame), 32'(14'b0_0101_10100101_1));
    chk("single_run", 32'(last_run), 32'd14);
    chk("single_nframes", 32'(frames - f0), 32'd1);

    // priority: add wins over mul/xor; no op bit gives tag 0
    cyc(1, 8'h3C, 8'b1000_1001);
    drain();
    chk("prio_frame", 32'(last_frame), 32'(14'b0_0001_00111100_1));
    f0 = frames;
    cyc(1, 8'h77, 8'h00);
    drain();
    chk("none_frame", 32'(last_frame), 32'(14'b0_0000_01110111_1));
    chk("none_sent", 32'(frames - f0), 32'd1);

    // overflow: 6 captures, sixth dropped
    f0 = frames;
    for (int i = 1; i <= 6; i++) begin
      cyc(1, 8'(i), 8'b0100_0000);
      if (i == 5) chk("ovf_full", 32'(bus.full), 32'd1);
    end
    chk("ovf_sticky", 32'(bus.overflow), 32'd1);
    drain();
    chk("ovf_nframes", 32'(frames - f0), 32'd5);
    chk("ovf_run", 32'(last_run), 32'd70);
    chk("ovf_last", 32'(last_frame), 32'(14'b0_0010_00000101_1));

    // back-to-back
    cyc(1, 8'h11, 8'b0000_0100);
    cyc(1, 8'h22, 8'b0000_0010);
    drain();
    chk("b2b_run", 32'(last_run), 32'd28);

    // reset mid-frame with 2 queued
    cyc(1, 8'hC1, 8'b0000_0001);
    cyc(1, 8'hC2, 8'b0000_0001);
    cyc(1, 8'hC3, 8'b0000_0001);
    begin
      int n = 0;
      while (!(m_busy && m_left == 8) && n < 50) begin cyc(0, 8'h00, 8'h00); n++; end
      if (n >= 50) chk("mid_wait_timeout", 32'(n), 32'd0);
    end
    chk("mid_queued", 32'(bus.fifo_count), 32'd2);
    chk("mid_fa_pre", 32'(bus.frame_active), 32'd1);
    rst_n = 0;
    #1;
    chk("mid_ser", 32'(bus.ser_out), 32'd1);
    chk("mid_fa", 32'(bus.frame_active), 32'd0);
    chk("mid_count", 32'(bus.fifo_count), 32'd0);
    model_clear();
    @(negedge clk);
    rst_n = 1;
    f0 = frames;
    for (int i = 0; i < 40; i++) cyc(0, 8'h00, 8'h00);
    chk("post_nframes", 32'(frames - f0), 32'd0);
    chk("post_count", 32'(bus.fifo_count), 32'd0);
    chk("post_ovf", 32'(bus.overflow), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_result_serializer.md
# alu_result_serializer

Downstream stage of the Tiny Tapeout nibble ALU. Each cycle it may capture the ALU's 8-bit result together with the one-hot operation select that produced it, and queue the pair in a small FIFO. It then drains the FIFO as fixed 14-bit serial frames on a single pin, so an external logic analyser or MCU can log a burst of results faster than it could sample the parallel bus.

## Interface

Parameters:
- DEPTH, 4: FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- cap  in  1  capture strobe; when high, `res_in`/`op_in` are sampled at the rising edge
- res_in  in  8  ALU result byte (the ALU's output bus)
- op_in  in  8  one-hot op select as driven to the ALU (bit7..bit0)
- ser_out  out  1  serial frame output; idles high
- frame_active  out  1  high during every cycle a frame bit is on `ser_out`
- fifo_count  out  $clog2(DEPTH)+1  entries queued (not counting the frame in flight)
- full  out  1  fifo_count == DEPTH
- empty  out  1  fifo_count == 0
- overflow  out  1  sticky; set when a capture is dropped; cleared only by reset

## Operation

- Tag encoding uses the same priority as the ALU (bit7 highest):
  - bit7 add → 1, bit6 negA → 2, bit5 negB → 3, bit4 sub → 4
  - bit3 mul → 5, bit2 and → 6, bit1 or → 7, bit0 xor → 8
  - no bit set → 0
- Each FIFO entry stores the 4-bit tag plus the 8-bit result (12 bits).
- Push: `cap` high and `full` low pre-edge. A `cap` while `full` is dropped and sets `overflow`, even if a pop occurs on the same edge.
- A simultaneous push and pop leaves `fifo_count` unchanged.
- Frame, 14 bits, sent in this order:
  - start bit 0
  - tag[3:0], MSB first
  - result[7:0], MSB first
  - stop bit 1
- The FSM has two states, IDLE and SHIFT.
  - IDLE & !empty: at the edge, pop the head, load the 14-bit shift register, reset the bit counter to 13, go to SHIFT.
  - SHIFT: shift one bit per edge, decrementing the counter.
  - Counter 0 (stop bit on `ser_out`): at the next edge, if !empty, pop and load the next frame directly (no idle gap); otherwise go to IDLE.
- `ser_out` = 1 and `frame_active` = 0 whenever in IDLE.

## Timing

- Reset values: `ser_out`=1, `frame_active`=0, `fifo_count`=0, `full`=0, `empty`=1, `overflow`=0. FIFO pointers are 0 and the state is IDLE.
- Reset asserted mid-frame aborts the frame immediately (asynchronous). Queued entries are discarded.
- Latency, for a push at edge N with the FIFO empty and the FSM in IDLE:
  - `fifo_count`=1 after edge N.
  - The pop happens at edge N+1; the start bit is on `ser_out` for the cycle after N+1.
  - Frame bits occupy the 14 cycles following edges N+1..N+14.
- A frame lasts exactly 14 cycles. The sustained drain rate is 1 entry per 14 cycles.
- `full`, `empty` and `fifo_count` are registered, updated at the same edge as push/pop, and consistent with each other in every cycle.
- Pointers wrap modulo DEPTH. `fifo_count` never exceeds DEPTH.

## Structure

- Package `alu_ser_pkg` holds:
  - the tag constants (TAG_NONE, TAG_ADD … TAG_XOR)
  - FRAME_LEN = 14
  - the `op_to_tag` priority-encode function
- Sub-module `result_fifo`: a parameterised synchronous FIFO, 12-bit wide, DEPTH deep. It has push/pop/full/empty/count outputs and its own async active-low reset.
- The top level contains the tag encoder, the push/overflow logic, the FSM and the shift register.

## Test plan

- Reset: hold `rst_n`=0 → `ser_out`=1, `empty`=1, `fifo_count`=0, `overflow`=0, `frame_active`=0.
- Single capture: `res_in`=8'hA5, `op_in`=8'b0000_1000 (mul, tag 5), `cap` for 1 cycle at edge N → cycles after N+1..N+14 show `ser_out` = 0, 0101, 10100101, 1. `frame_active` is high for those 14 cycles, then `ser_out` returns to 1.
- Priority: `op_in`=8'b1000_1001 → tag 1. `op_in`=0 → tag 0, and the frame is still sent.
- Overflow: `cap` high for 6 consecutive edges N..N+5 with `res_in`=1..6.
  - `full`=1 after N+4, and the push at N+5 is dropped; `overflow`=1.
  - Five frames are emitted back-to-back with results 1..5, 70 cycles with no idle gap.
- Back-to-back: two captures on consecutive edges → the second start bit immediately follows the first stop bit. There are 28 contiguous `frame_active` cycles, then IDLE.
- Reset mid-frame: drop `rst_n` during bit 5 of a frame with 2 entries queued → `ser_out`=1 at once. After release there are no further frames, `fifo_count`=0 and `overflow`=0.
